// File: rtl/accelerator_vector_stream_controller.sv
// rtl/accelerator_vector_stream_controller.sv - streaming matrix-vector engine, h[l] = sum W[l][x]*x[x] + b[l]
// Sequences the L/X loops itself, pulls operands by request/response pulses and streams one result per row.
module accelerator_vector_stream_controller #(
  parameter int DATA_SIZE    = 128,
  parameter int CONTROL_SIZE = 4,
  parameter int MAX_L        = 64,
  parameter int MAX_X        = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [CONTROL_SIZE-1:0] MODE,
  input  logic [DATA_SIZE-1:0]    SIZE_L_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_X_IN,
  output logic                    B_OUT_ENABLE,
  input  logic                    B_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    B_IN,
  output logic                    W_OUT_L_ENABLE,
  output logic                    W_OUT_X_ENABLE,
  input  logic                    W_IN_X_ENABLE,
  input  logic [DATA_SIZE-1:0]    W_IN,
  output logic                    X_OUT_ENABLE,
  input  logic                    X_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    X_IN,
  output logic                    H_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    H_OUT
);
  localparam int LW = $clog2(MAX_L + 1);
  localparam int XW = $clog2(MAX_X + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_B, S_WAIT_B, S_REQ_WX, S_WAIT_WX, S_MAC, S_EMIT, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   nobias_q, nobias_d;
  logic [LW-1:0]          sl_q, sl_d, l_q, l_d;
  logic [XW-1:0]          sx_q, sx_d, x_q, x_d;
  logic [DATA_SIZE-1:0]   acc_q, acc_d;
  logic [DATA_SIZE-1:0]   w_q, w_d, xv_q, xv_d;
  logic                   w_got_q, w_got_d, x_got_q, x_got_d;
  logic [DATA_SIZE-1:0]   h_q, h_d;
  logic                   h_en_q, h_en_d;
  logic                   ready_q, ready_d;
  logic                   b_req_q, b_req_d;
  logic                   wx_req_q, wx_req_d;
  logic                   wl_req_q, wl_req_d;
  logic [LW-1:0]          sl_clamp;
  logic [XW-1:0]          sx_clamp;
  logic                   unused_mode;

  // Only MODE[0] selects behaviour; the remaining bits are reserved.
  assign unused_mode = ^MODE;

  always_comb begin
    sl_clamp = (SIZE_L_IN > DATA_SIZE'(MAX_L)) ? LW'(MAX_L) : LW'(SIZE_L_IN);
    sx_clamp = (SIZE_X_IN > DATA_SIZE'(MAX_X)) ? XW'(MAX_X) : XW'(SIZE_X_IN);
  end

  always_comb begin
    state_d  = state_q;
    nobias_d = nobias_q;
    sl_d     = sl_q;
    sx_d     = sx_q;
    l_d      = l_q;
    x_d      = x_q;
    acc_d    = acc_q;
    w_d      = w_q;
    xv_d     = xv_q;
    w_got_d  = w_got_q;
    x_got_d  = x_got_q;
    h_d      = h_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          nobias_d = MODE[0];
          sl_d     = sl_clamp;
          sx_d     = sx_clamp;
          l_d      = '0;
          x_d      = '0;
          acc_d    = '0;
          if (sl_clamp == '0 || sx_clamp == '0) state_d = S_DONE;
          else if (MODE[0])                     state_d = S_REQ_WX;
          else                                  state_d = S_REQ_B;
        end
      end
      S_REQ_B:  state_d = S_WAIT_B;
      S_WAIT_B: begin
        if (B_IN_ENABLE) begin
          acc_d   = B_IN;
          state_d = S_REQ_WX;
        end
      end
      S_REQ_WX: begin
        w_got_d = 1'b0;
        x_got_d = 1'b0;
        state_d = S_WAIT_WX;
      end
      S_WAIT_WX: begin
        // Each operand is taken once; late duplicates must not overwrite it.
        if (W_IN_X_ENABLE && !w_got_q) begin
          w_d     = W_IN;
          w_got_d = 1'b1;
        end
        if (X_IN_ENABLE && !x_got_q) begin
          xv_d    = X_IN;
          x_got_d = 1'b1;
        end
        if (w_got_d && x_got_d) state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + w_q * xv_q;
        if ((x_q + XW'(1)) < sx_q) begin
          x_d     = x_q + XW'(1);
          state_d = S_REQ_WX;
        end else begin
          h_d     = acc_d;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if ((l_q + LW'(1)) < sl_q) begin
          l_d     = l_q + LW'(1);
          x_d     = '0;
          acc_d   = '0;
          state_d = nobias_q ? S_REQ_WX : S_REQ_B;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they coincide with the state they belong to.
    b_req_d  = (state_d == S_REQ_B);
    wx_req_d = (state_d == S_REQ_WX);
    wl_req_d = (state_d == S_REQ_WX) && (x_d == '0);
    h_en_d   = (state_d == S_EMIT);
    ready_d  = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      nobias_q <= 1'b0;
      sl_q     <= '0;
      sx_q     <= '0;
      l_q      <= '0;
      x_q      <= '0;
      acc_q    <= '0;
      w_q      <= '0;
      xv_q     <= '0;
      w_got_q  <= 1'b0;
      x_got_q  <= 1'b0;
      h_q      <= '0;
      h_en_q   <= 1'b0;
      ready_q  <= 1'b0;
      b_req_q  <= 1'b0;
      wx_req_q <= 1'b0;
      wl_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      nobias_q <= nobias_d;
      sl_q     <= sl_d;
      sx_q     <= sx_d;
      l_q      <= l_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      w_q      <= w_d;
      xv_q     <= xv_d;
      w_got_q  <= w_got_d;
      x_got_q  <= x_got_d;
      h_q      <= h_d;
      h_en_q   <= h_en_d;
      ready_q  <= ready_d;
      b_req_q  <= b_req_d;
      wx_req_q <= wx_req_d;
      wl_req_q <= wl_req_d;
    end
  end

  assign READY          = ready_q;
  assign B_OUT_ENABLE   = b_req_q;
  assign W_OUT_L_ENABLE = wl_req_q;
  assign W_OUT_X_ENABLE = wx_req_q;
  assign X_OUT_ENABLE   = wx_req_q;
  assign H_OUT_ENABLE   = h_en_q;
  assign H_OUT          = h_q;

endmodule

// File: doc/accelerator_vector_stream_controller.md
Name: accelerator_vector_stream_controller

Overview:
- Parametrised streaming matrix-vector engine for the NTM controller datapath: computes h[l] = sum over x of W[l][x]*x[x] + b[l] for l in 0..L-1.
- Sequences the nested L/X loops itself and pulls operands element-by-element via *_OUT_ENABLE request / *_IN_ENABLE response handshakes.
- Adds what the fixed top-level flow lacks: runtime-sized loops clamped to compile-time maxima, a bias-bypass mode, skew-tolerant operand capture, and a streamed per-row result.

Parameters:
- DATA_SIZE, 128, width of every data word, size word and accumulator.
- CONTROL_SIZE, 4, width of the MODE input; only bit 0 is used.
- MAX_L, 64, maximum rows; SIZE_L_IN is clamped to this value; sets the l-counter width.
- MAX_X, 64, maximum columns; SIZE_X_IN is clamped to this value; sets the x-counter width.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin a run; sampled only in IDLE.
- READY  out  1  one-cycle pulse when a run completes.
- MODE  in  CONTROL_SIZE  bit0=0: add bias; bit0=1: no bias. Latched at START.
- SIZE_L_IN  in  DATA_SIZE  row count; latched at START.
- SIZE_X_IN  in  DATA_SIZE  column count; latched at START.
- B_OUT_ENABLE  out  1  request pulse for b[l].
- B_IN_ENABLE  in  1  B_IN valid.
- B_IN  in  DATA_SIZE  bias element.
- W_OUT_L_ENABLE  out  1  pulse with the first W request of each row.
- W_OUT_X_ENABLE  out  1  request pulse for W[l][x].
- W_IN_X_ENABLE  in  1  W_IN valid.
- W_IN  in  DATA_SIZE  weight element.
- X_OUT_ENABLE  out  1  request pulse for x[x].
- X_IN_ENABLE  in  1  X_IN valid.
- X_IN  in  DATA_SIZE  input element.
- H_OUT_ENABLE  out  1  H_OUT valid pulse, once per row.
- H_OUT  out  DATA_SIZE  row result.

Behaviour:
- Reset: all outputs 0, accumulator and counters 0, FSM in IDLE. RST mid-run aborts immediately with no READY. RST has priority over START.
- FSM states: IDLE, REQ_B, WAIT_B, REQ_WX, WAIT_WX, MAC, EMIT, DONE.
- IDLE:
  - START=1 latches MODE and sizes; each size is clamped to its MAX; l=0, x=0.
  - If either clamped size is 0, go to DONE.
  - Otherwise go to REQ_B if MODE[0]=0, else REQ_WX with acc=0.
  - START in any other state is ignored.
- REQ_B: B_OUT_ENABLE=1 for one cycle, then go to WAIT_B.
- WAIT_B: on B_IN_ENABLE=1, acc<=B_IN and go to REQ_WX.
- REQ_WX: W_OUT_X_ENABLE=1 and X_OUT_ENABLE=1 for one cycle. W_OUT_L_ENABLE=1 additionally when x=0. Go to WAIT_WX.
- WAIT_WX:
  - W and X are captured independently on their IN enables, in the same cycle or different cycles.
  - A repeated enable for an operand already captured is ignored.
  - In the cycle both are captured (including the same-cycle case), go to MAC.
- MAC: acc<=acc+W*X, low DATA_SIZE bits, two's-complement wraparound; no saturation. Then:
  - if x<SX-1: x++, go to REQ_WX;
  - else go to EMIT.
- EMIT:
  - H_OUT<=acc and H_OUT_ENABLE=1 for one cycle. H_OUT holds its value until the next EMIT or reset.
  - Then: if l<SL-1, l++, x=0, acc=0, go to REQ_B or REQ_WX per latched mode; else go to DONE.
- DONE: READY=1 for one cycle, then IDLE.
- IN_ENABLEs outside their WAIT state are ignored; data is not captured.
- Minimum per-element cost is 3 cycles: request, response at the earliest the next cycle, MAC. Bias costs 2 extra cycles per row in mode 0. EMIT costs 1 cycle per row.
- Zero-wait example: START at cycle 0 gives the first W/X request at cycle 1 in mode 1, or at cycle 3 in mode 0.

Test Plan:
- Mode 0, SIZE_L_IN=2, SIZE_X_IN=3, W=[[1,2,3],[4,5,6]], x=[1,1,2], b=[10,-1], responses 1 cycle after each request -> H_OUT 19 then 20. Two H_OUT_ENABLE pulses, two W_OUT_L_ENABLE pulses, six W_OUT_X_ENABLE pulses, then one READY pulse.
- Same data with MODE=1 -> H_OUT 9 then 21. B_OUT_ENABLE never asserted.
- Skew: X_IN_ENABLE 4 cycles after W_IN_X_ENABLE, a duplicate W_IN_X_ENABLE, and stray enables and START pulses mid-run -> results still 19 and 20. Exactly 6 MACs; no extra requests.
- SIZE_L_IN=0, or SIZE_X_IN=0, with START -> READY the cycle after START. No requests and no H_OUT_ENABLE.
- DATA_SIZE=8, mode 0, L=X=1, W=127, x=127, b=0 -> H_OUT=8'h01 (wraparound). SIZE_X_IN=200 with MAX_X=64 -> exactly 64 W/X requests per row.
- RST asserted during WAIT_WX of row 1 -> all outputs 0 after that edge, no READY. A new START then runs test 1 cleanly with results 19 and 20.
